// File: rtl/ser_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional parity build: define SER_TX_PARITY_EN.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width, with headroom for a trailing parity bit.
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

  localparam logic IDLE_Q = 1'b0;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register for ser_tx_shift.
// The ready flag is registered so it never depends on load_valid.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             ready_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q, full_d;
  logic             ready_q;

  always_comb begin
    full_d = full_q;
    if (rd_i) full_d = 1'b0;
    if (wr_i) full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (wr_i) data_q <= din_i;
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  assign dout_o  = data_q;
  assign full_o  = full_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/ser_tx_shift.sv
// Parallel-to-serial transmitter with gapless word chaining.
// Define SER_TX_PARITY_EN to append an even-parity bit per frame.
module ser_tx_shift
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_w(WIDTH);
`ifdef SER_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  function automatic logic bit_of(input logic [WIDTH-1:0] w,
                                  input logic [CNT_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      if (i == CNT_W'(k)) b = MSB_FIRST ? w[WIDTH-1-k] : w[k];
`ifdef SER_TX_PARITY_EN
    if (i == CNT_W'(WIDTH)) b = ^w;
`endif
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nxt;
  logic             q_q, q_d;
  logic             qv_q, qv_d;
  logic             done_q, done_d;
  logic             acc, last, ld;
  logic [WIDTH-1:0] ld_w, hold_w;
  logic             hold_wr, hold_rd, hold_full;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (hold_wr),
    .din_i   (din),
    .rd_i    (hold_rd),
    .dout_o  (hold_w),
    .full_o  (hold_full),
    .ready_o (load_ready)
  );

  always_comb begin
    acc     = load_valid && load_ready;
    last    = (state_q == SHIFT) && (cnt_q == LAST);
    nxt     = cnt_q + 1'b1;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    q_d     = IDLE_Q;
    qv_d    = 1'b0;
    done_d  = 1'b0;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    ld      = 1'b0;
    ld_w    = din;
    unique case (1'b1)
      (state_q == IDLE): ld = acc;
      (state_q == SHIFT && !last): begin
        cnt_d   = nxt;
        q_d     = bit_of(sh_q, nxt);
        qv_d    = 1'b1;
        done_d  = (nxt == LAST);
        hold_wr = acc;
      end
      last: begin
        // Held word wins; the hold is empty whenever acc can be true.
        hold_rd = hold_full;
        ld      = hold_full || acc;
        ld_w    = hold_full ? hold_w : din;
        if (!ld) state_d = IDLE;
      end
      default: ;
    endcase
    if (ld) begin
      state_d = SHIFT;
      sh_d    = ld_w;
      cnt_d   = '0;
      q_d     = bit_of(ld_w, '0);
      qv_d    = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      q_q     <= IDLE_Q;
      qv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign q_valid = qv_q;
  assign done    = done_q;
  assign busy    = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_ser_tx_shift.sv
// Directed bench for ser_tx_shift (MSB-first and LSB-first instances).
// The parity frame is exercised when SER_TX_PARITY_EN is defined.
module tb_ser_tx_shift;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic       lv = 1'b0;
  logic       lr, q, qv, busy, done;
  logic [7:0] din2 = '0;
  logic       lv2 = 1'b0;
  logic       lr2, q2, qv2, busy2, done2;
  int         total = 0;
  int         bad = 0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [23:0] s3;
  logic [8:0]  sp;

  ser_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .din(din), .load_valid(lv),
    .load_ready(lr), .q(q), .q_valid(qv), .busy(busy), .done(done)
  );

  ser_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din2), .load_valid(lv2),
    .load_ready(lr2), .q(q2), .q_valid(qv2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_q", q, 0);
    chk("rst_qv", qv, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", lr, 1);
    reset = 1'b1;
    tick;

`ifdef SER_TX_PARITY_EN
    din = 8'h07; lv = 1'b1; tick; lv = 1'b0;
    sp = 9'b0000_0111_1;
    for (int c = 1; c <= 9; c++) begin
      chk("par_q", q, sp[9-c]);
      chk("par_qv", qv, 1);
      chk("par_done", done, c == 9);
      tick;
    end
    chk("par_end_qv", qv, 0);
`else
    // single word
    din = 8'hA5; lv = 1'b1; tick; lv = 1'b0;
    s1 = 8'hA5;
    for (int c = 1; c <= 8; c++) begin
      chk("one_q", q, s1[8-c]);
      chk("one_qv", qv, 1);
      chk("one_done", done, c == 8);
      chk("one_busy", busy, 1);
      tick;
    end
    chk("one_end_qv", qv, 0);
    chk("one_end_q", q, 0);
    chk("one_end_busy", busy, 0);

    // back-to-back through the hold buffer
    din = 8'hA5; lv = 1'b1; tick; lv = 1'b0;
    s2 = 16'hA53C;
    for (int c = 1; c <= 16; c++) begin
      chk("b2b_q", q, s2[16-c]);
      chk("b2b_qv", qv, 1);
      chk("b2b_done", done, (c == 8) || (c == 16));
      chk("b2b_ready", lr, !(c >= 4 && c <= 8));
      if (c == 3) begin lv = 1'b1; din = 8'h3C; end
      else lv = 1'b0;
      tick;
    end
    chk("b2b_end_qv", qv, 0);
    chk("b2b_end_busy", busy, 0);

    // backpressure: FF waits while the hold is full
    din = 8'hA5; lv = 1'b1; tick; lv = 1'b0;
    s3 = 24'hA53CFF;
    for (int c = 1; c <= 24; c++) begin
      chk("bp_q", q, s3[24-c]);
      chk("bp_qv", qv, 1);
      chk("bp_done", done, (c == 8) || (c == 16) || (c == 24));
      chk("bp_ready", lr, !((c >= 3 && c <= 8) || (c >= 10 && c <= 16)));
      if (c == 2) begin lv = 1'b1; din = 8'h3C; end
      else if (c >= 4 && c <= 9) begin lv = 1'b1; din = 8'hFF; end
      else lv = 1'b0;
      tick;
    end
    chk("bp_end_qv", qv, 0);

    // reset mid-frame
    din = 8'hA5; lv = 1'b1; tick; lv = 1'b0;
    tick; tick; tick;
    chk("mid_qv_before", qv, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_q", q, 0);
    chk("mid_qv", qv, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", lr, 1);
    chk("mid_done", done, 0);
    tick;
    #2 reset = 1'b1;
    tick;
    chk("post_qv", qv, 0);
    chk("post_busy", busy, 0);
    din = 8'h81; lv = 1'b1; tick; lv = 1'b0;
    s1 = 8'h81;
    for (int c = 1; c <= 8; c++) begin
      chk("post_q", q, s1[8-c]);
      chk("post_done", done, c == 8);
      tick;
    end
    chk("post_end_qv", qv, 0);

    // LSB-first instance
    din2 = 8'h01; lv2 = 1'b1; tick; lv2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("lsb_q", q2, c == 1);
      chk("lsb_qv", qv2, 1);
      chk("lsb_done", done2, c == 8);
      tick;
    end
    chk("lsb_end_qv", qv2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
